// File: rtl/decode_stage.sv
// decode_stage: registered RV instruction decode feeding execute,
// with a 2-entry skid buffer so backpressure never costs throughput.
package decode_pkg;

   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_ARITH     = 7'b0010011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_R_TYPE    = 7'b0110011;
   localparam logic [6:0] OP_RV64_TYPE = 7'b0111011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;

   localparam logic [6:0] F7_NORMAL = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   typedef enum logic [1:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J
   } imm_src_t;

   typedef enum logic [1:0] {
      RESULT_ALU,
      RESULT_MEM,
      RESULT_JUMP
   } result_src_t;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_ctrl_t;

   typedef struct packed {
      logic        pc_src;
      logic        alu_src;
      imm_src_t    imm_src;
      result_src_t result_src;
      logic        reg_write;
      logic        mem_write;
      alu_ctrl_t   alu_control;
      logic        alu_word;
   } control_signals_t;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [11:0] imm_i;
      logic [11:0] imm_s;
      logic [12:0] imm_b;
      logic [20:0] imm_j;
   } decoded_instr_t;

endpackage

module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output decoded_instr_t   out_dec,
   output logic [XLEN-1:0]  out_imm,
   output control_signals_t out_ctrl,
   output logic             out_branch,
   output logic             out_jump,
   output logic             out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      decoded_instr_t   dec;
      logic [XLEN-1:0]  imm;
      control_signals_t ctrl;
      logic             branch;
      logic             jump;
      logic             illegal;
   } entry_t;

   localparam logic [5:0] REG_LIM = 6'(REG_COUNT);

   decoded_instr_t   dec;
   control_signals_t ctrl_raw;
   control_signals_t ctrl_dec;
   alu_ctrl_t        f3_alu;
   logic [XLEN-1:0]  imm;

   logic is_load;
   logic is_arith;
   logic is_store;
   logic is_r;
   logic is_rv64;
   logic is_branch;
   logic is_jal;
   logic sub_en;

   logic branch_raw;
   logic jump_raw;
   logic use_rd;
   logic use_rs1;
   logic use_rs2;
   logic bad_op;
   logic bad_f7;
   logic bad_reg;
   logic illegal;

   entry_t din;
   entry_t main_q;
   entry_t skid_q;
   logic   main_valid;
   logic   skid_valid;
   logic   accept;
   logic   main_load;

   assign dec.op     = in_instr[6:0];
   assign dec.rd     = in_instr[11:7];
   assign dec.funct3 = in_instr[14:12];
   assign dec.rs1    = in_instr[19:15];
   assign dec.rs2    = in_instr[24:20];
   assign dec.funct7 = in_instr[31:25];
   assign dec.imm_i  = in_instr[31:20];
   assign dec.imm_s  = {in_instr[31:25], in_instr[11:7]};
   assign dec.imm_b  = {in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
   assign dec.imm_j  = {in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};

   assign is_load   = dec.op == OP_LOAD;
   assign is_arith  = dec.op == OP_ARITH;
   assign is_store  = dec.op == OP_STORE;
   assign is_r      = dec.op == OP_R_TYPE;
   assign is_rv64   = dec.op == OP_RV64_TYPE;
   assign is_branch = dec.op == OP_BRANCH;
   assign is_jal    = dec.op == OP_JAL;

   // instr[30] selects SUB only for register-register forms; ADDI has no SUB.
   assign sub_en = is_r | is_rv64;

   always_comb begin
      f3_alu = ALU_ADD;
      unique case (dec.funct3)
         3'd0: f3_alu = (sub_en & in_instr[30]) ? ALU_SUB : ALU_ADD;
         3'd1: f3_alu = ALU_SLL;
         3'd2: f3_alu = ALU_SLT;
         3'd3: f3_alu = ALU_SLTU;
         3'd4: f3_alu = ALU_XOR;
         3'd5: f3_alu = in_instr[30] ? ALU_SRA : ALU_SRL;
         3'd6: f3_alu = ALU_OR;
         3'd7: f3_alu = ALU_AND;
      endcase
   end

   always_comb begin
      ctrl_raw   = '0;
      branch_raw = 1'b0;
      jump_raw   = 1'b0;
      use_rd     = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      bad_op     = 1'b0;
      unique case (1'b1)
         is_load: begin
            ctrl_raw.alu_src     = 1'b1;
            ctrl_raw.imm_src     = IMM_I;
            ctrl_raw.result_src  = RESULT_MEM;
            ctrl_raw.reg_write   = 1'b1;
            ctrl_raw.alu_control = ALU_ADD;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
         end
         is_arith: begin
            ctrl_raw.alu_src     = 1'b1;
            ctrl_raw.imm_src     = IMM_I;
            ctrl_raw.result_src  = RESULT_ALU;
            ctrl_raw.reg_write   = 1'b1;
            ctrl_raw.alu_control = f3_alu;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
         end
         is_store: begin
            ctrl_raw.alu_src     = 1'b1;
            ctrl_raw.imm_src     = IMM_S;
            ctrl_raw.result_src  = RESULT_ALU;
            ctrl_raw.mem_write   = 1'b1;
            ctrl_raw.alu_control = ALU_ADD;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         is_r, is_rv64: begin
            ctrl_raw.alu_src     = 1'b0;
            ctrl_raw.imm_src     = IMM_I;
            ctrl_raw.result_src  = RESULT_ALU;
            ctrl_raw.reg_write   = 1'b1;
            ctrl_raw.alu_control = f3_alu;
            ctrl_raw.alu_word    = is_rv64;
            bad_op  = is_rv64 & (XLEN != 64);
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         is_branch: begin
            ctrl_raw.alu_src     = 1'b0;
            ctrl_raw.imm_src     = IMM_B;
            ctrl_raw.result_src  = RESULT_ALU;
            ctrl_raw.alu_control = ALU_SUB;
            branch_raw = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         is_jal: begin
            ctrl_raw.imm_src     = IMM_J;
            ctrl_raw.result_src  = RESULT_JUMP;
            ctrl_raw.reg_write   = 1'b1;
            ctrl_raw.alu_control = ALU_ADD;
            jump_raw = 1'b1;
            use_rd   = 1'b1;
         end
         default: bad_op = 1'b1;
      endcase
   end

   assign bad_f7 = sub_en &
                   (dec.funct7 != F7_NORMAL) &
                   (dec.funct7 != F7_ALT);

   assign bad_reg = (use_rd  & ({1'b0, dec.rd}  >= REG_LIM)) |
                    (use_rs1 & ({1'b0, dec.rs1} >= REG_LIM)) |
                    (use_rs2 & ({1'b0, dec.rs2} >= REG_LIM));

   assign illegal = bad_op | bad_f7 | bad_reg;

   // An illegal entry must have no architectural side effects downstream.
   assign ctrl_dec = illegal ? '0 : ctrl_raw;

   always_comb begin
      imm = {{(XLEN-12){in_instr[31]}}, dec.imm_i};
      unique case (ctrl_dec.imm_src)
         IMM_I: imm = {{(XLEN-12){in_instr[31]}}, dec.imm_i};
         IMM_S: imm = {{(XLEN-12){in_instr[31]}}, dec.imm_s};
         IMM_B: imm = {{(XLEN-13){in_instr[31]}}, dec.imm_b};
         IMM_J: imm = {{(XLEN-21){in_instr[31]}}, dec.imm_j};
      endcase
   end

   assign din.pc      = in_pc;
   assign din.dec     = dec;
   assign din.imm     = imm;
   assign din.ctrl    = ctrl_dec;
   assign din.branch  = branch_raw & ~illegal;
   assign din.jump    = jump_raw & ~illegal;
   assign din.illegal = illegal;

   assign in_ready  = ~skid_valid;
   assign accept    = in_valid & in_ready;
   assign main_load = ~main_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_load) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= din;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= din;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid   = main_valid;
   assign out_pc      = main_q.pc;
   assign out_dec     = main_q.dec;
   assign out_imm     = main_q.imm;
   assign out_ctrl    = main_q.ctrl;
   assign out_branch  = main_q.branch;
   assign out_jump    = main_q.jump;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage
// against an ISA-level decode model and a depth-2 FIFO model.
`timescale 1ns/1ps
module tb_decode_stage;
   import decode_pkg::*;

   typedef struct packed {
      logic [31:0]      pc;
      decoded_instr_t   dec;
      logic [31:0]      imm;
      control_signals_t ctrl;
      logic             br;
      logic             jp;
      logic             il;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;

   logic             a_in_ready, a_out_valid;
   logic [31:0]      a_pc, a_imm;
   decoded_instr_t   a_dec;
   control_signals_t a_ctrl;
   logic             a_branch, a_jump, a_illegal;

   logic             b_in_ready, b_out_valid;
   logic [63:0]      b_pc, b_imm;
   decoded_instr_t   b_dec;
   control_signals_t b_ctrl;
   logic             b_branch, b_jump, b_illegal;

   logic             c_in_ready, c_out_valid;
   logic [31:0]      c_pc, c_imm;
   decoded_instr_t   c_dec;
   control_signals_t c_ctrl;
   logic             c_branch, c_jump, c_illegal;

   exp_t got_a, got_c;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .REG_COUNT(32)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_pc), .out_dec(a_dec), .out_imm(a_imm),
      .out_ctrl(a_ctrl), .out_branch(a_branch),
      .out_jump(a_jump), .out_illegal(a_illegal)
   );

   decode_stage #(.XLEN(64), .REG_COUNT(32)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc({32'h0, in_pc}),
      .out_valid(b_out_valid), .out_ready(1'b1),
      .out_pc(b_pc), .out_dec(b_dec), .out_imm(b_imm),
      .out_ctrl(b_ctrl), .out_branch(b_branch),
      .out_jump(b_jump), .out_illegal(b_illegal)
   );

   decode_stage #(.XLEN(32), .REG_COUNT(16)) dut_c (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(c_in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(c_out_valid), .out_ready(1'b1),
      .out_pc(c_pc), .out_dec(c_dec), .out_imm(c_imm),
      .out_ctrl(c_ctrl), .out_branch(c_branch),
      .out_jump(c_jump), .out_illegal(c_illegal)
   );

   assign got_a = {a_pc, a_dec, a_imm, a_ctrl, a_branch, a_jump, a_illegal};
   assign got_c = {c_pc, c_dec, c_imm, c_ctrl, c_branch, c_jump, c_illegal};

   function automatic exp_t model(input logic [31:0] ins,
                                  input logic [31:0] pc,
                                  input int xlen, input int regs);
      exp_t      e;
      alu_ctrl_t tbl [8];
      alu_ctrl_t alu;
      logic      legal, urd, urs1, urs2;
      int        imm;
      tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      e = '0;
      e.pc = pc;
      e.dec.op     = ins[6:0];
      e.dec.rd     = ins[11:7];
      e.dec.funct3 = ins[14:12];
      e.dec.rs1    = ins[19:15];
      e.dec.rs2    = ins[24:20];
      e.dec.funct7 = ins[31:25];
      e.dec.imm_i  = ins[31:20];
      e.dec.imm_s  = {ins[31:25], ins[11:7]};
      e.dec.imm_b  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      e.dec.imm_j  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      alu = tbl[ins[14:12]];
      if (ins[14:12] == 3'd5 && ins[30]) alu = ALU_SRA;
      legal = 1'b1;
      urd = 1'b0; urs1 = 1'b0; urs2 = 1'b0;
      case (ins[6:0])
         7'h03: begin
            e.ctrl.alu_src = 1'b1; e.ctrl.imm_src = IMM_I;
            e.ctrl.result_src = RESULT_MEM; e.ctrl.reg_write = 1'b1;
            e.ctrl.alu_control = ALU_ADD; urd = 1'b1; urs1 = 1'b1;
         end
         7'h13: begin
            e.ctrl.alu_src = 1'b1; e.ctrl.imm_src = IMM_I;
            e.ctrl.result_src = RESULT_ALU; e.ctrl.reg_write = 1'b1;
            e.ctrl.alu_control = alu; urd = 1'b1; urs1 = 1'b1;
         end
         7'h23: begin
            e.ctrl.alu_src = 1'b1; e.ctrl.imm_src = IMM_S;
            e.ctrl.mem_write = 1'b1; e.ctrl.alu_control = ALU_ADD;
            urs1 = 1'b1; urs2 = 1'b1;
         end
         7'h33, 7'h3B: begin
            e.ctrl.imm_src = IMM_I; e.ctrl.reg_write = 1'b1;
            e.ctrl.alu_control =
               (ins[14:12] == 3'd0 && ins[30]) ? ALU_SUB : alu;
            if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) legal = 1'b0;
            if (ins[6:0] == 7'h3B) begin
               e.ctrl.alu_word = 1'b1;
               if (xlen != 64) legal = 1'b0;
            end
            urd = 1'b1; urs1 = 1'b1; urs2 = 1'b1;
         end
         7'h63: begin
            e.ctrl.imm_src = IMM_B; e.ctrl.alu_control = ALU_SUB;
            e.br = 1'b1; urs1 = 1'b1; urs2 = 1'b1;
         end
         7'h6F: begin
            e.ctrl.imm_src = IMM_J; e.ctrl.result_src = RESULT_JUMP;
            e.ctrl.reg_write = 1'b1; e.ctrl.alu_control = ALU_ADD;
            e.jp = 1'b1; urd = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (urd  && int'(ins[11:7])  >= regs) legal = 1'b0;
      if (urs1 && int'(ins[19:15]) >= regs) legal = 1'b0;
      if (urs2 && int'(ins[24:20]) >= regs) legal = 1'b0;
      if (!legal) begin
         e.ctrl = '0; e.br = 1'b0; e.jp = 1'b0; e.il = 1'b1;
      end
      case (e.ctrl.imm_src)
         IMM_S:   imm = $signed({ins[31:25], ins[11:7]});
         IMM_B:   imm = $signed(e.dec.imm_b);
         IMM_J:   imm = $signed(e.dec.imm_j);
         default: imm = $signed(ins[31:20]);
      endcase
      e.imm = 32'(imm);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: r[6:0] = 7'h03;
         1: r[6:0] = 7'h13;
         2: r[6:0] = 7'h23;
         3: r[6:0] = 7'h33;
         4: r[6:0] = 7'h3B;
         5: r[6:0] = 7'h63;
         6: r[6:0] = 7'h6F;
         default: r[6:0] = 7'($urandom);
      endcase
      if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
         r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 32'h100);
      tick(); tick();
      tests++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_hs ready=%b valid=%b required 1 0",
                  a_in_ready, a_out_valid);
      end
      tests++;
      if (got_a !== '0) begin
         fails++;
         $display("FAIL reset_payload got=%h required 0", got_a);
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_addi();
      exp_t e;
      e = model(32'hFFF00093, 32'h1000, 32, 32);
      out_ready = 1'b1;
      drive(1'b1, 32'hFFF00093, 32'h1000);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_out_valid !== 1'b1 || a_dec.rd !== 5'd1 ||
          a_imm !== 32'hFFFFFFFF) begin
         fails++;
         $display("FAIL addi_fields v=%b rd=%0d imm=%h required 1 1 ffffffff",
                  a_out_valid, a_dec.rd, a_imm);
      end
      tests++;
      if (a_ctrl.alu_control !== ALU_ADD || a_ctrl.reg_write !== 1'b1 ||
          a_ctrl.alu_src !== 1'b1 || a_ctrl.result_src !== RESULT_ALU) begin
         fails++;
         $display("FAIL addi_ctrl got=%h required alu=ADD rw=1 src=1 res=ALU",
                  a_ctrl);
      end
      tests++;
      if (got_a !== e) begin
         fails++;
         $display("FAIL addi_model got=%h required=%h", got_a, e);
      end
      tick();
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL addi_drain valid=%b required 0", a_out_valid);
      end
   endtask

   task automatic test_decode_basic();
      logic [31:0] ins [3];
      logic [31:0] imm [3];
      ins = '{32'h402081B3, 32'hFE000EE3, 32'h008000EF};
      imm = '{32'h00000402, 32'hFFFFFFFC, 32'h00000008};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ins[i], 32'h2000 + 32'(i * 4));
         tick();
         tests++;
         if (got_a !== model(ins[i], 32'h2000 + 32'(i * 4), 32, 32)) begin
            fails++;
            $display("FAIL basic_model[%0d] got=%h required=%h", i, got_a,
                     model(ins[i], 32'h2000 + 32'(i * 4), 32, 32));
         end
         tests++;
         if (a_imm !== imm[i] || a_branch !== (i == 1) ||
             a_jump !== (i == 2)) begin
            fails++;
            $display("FAIL basic_imm[%0d] imm=%h br=%b jp=%b required imm=%h",
                     i, a_imm, a_branch, a_jump, imm[i]);
         end
      end
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_ctrl.result_src !== RESULT_JUMP) begin
         fails++;
         $display("FAIL jal_result got=%0d required RESULT_JUMP",
                  a_ctrl.result_src);
      end
      tick();
   endtask

   task automatic test_skid();
      exp_t ea, eb, ec;
      ea = model(32'hFFF00093, 32'h200, 32, 32);
      eb = model(32'h402081B3, 32'h204, 32, 32);
      ec = model(32'h008000EF, 32'h208, 32, 32);
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 32'h200); tick();
      drive(1'b1, 32'h402081B3, 32'h204); tick();
      drive(1'b1, 32'h008000EF, 32'h208); tick();
      tests++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || got_a !== ea) begin
         fails++;
         $display("FAIL skid_full v=%b rdy=%b got=%h required 1 0 %h",
                  a_out_valid, a_in_ready, got_a, ea);
      end
      out_ready = 1'b1;
      tick();
      tests++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || got_a !== eb) begin
         fails++;
         $display("FAIL skid_b v=%b rdy=%b got=%h required 1 1 %h",
                  a_out_valid, a_in_ready, got_a, eb);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_out_valid !== 1'b1 || got_a !== ec) begin
         fails++;
         $display("FAIL skid_c v=%b got=%h required 1 %h",
                  a_out_valid, got_a, ec);
      end
      tick();
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL skid_empty valid=%b required 0", a_out_valid);
      end
   endtask

   task automatic test_flush();
      exp_t ee;
      ee = model(32'h00112023, 32'h40C, 32, 32);
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 32'h400); tick();
      drive(1'b1, 32'h402081B3, 32'h404); tick();
      drive(1'b1, 32'h008000EF, 32'h408);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_full v=%b rdy=%b required 0 1",
                  a_out_valid, a_in_ready);
      end
      out_ready = 1'b1;
      drive(1'b1, 32'hFE000EE3, 32'h410);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_accept v=%b rdy=%b required 0 1",
                  a_out_valid, a_in_ready);
      end
      drive(1'b1, 32'h00112023, 32'h40C);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_out_valid !== 1'b1 || got_a !== ee) begin
         fails++;
         $display("FAIL flush_after v=%b got=%h required 1 %h",
                  a_out_valid, got_a, ee);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 32'h500); tick();
      drive(1'b1, 32'h402081B3, 32'h504); tick();
      drive(1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || got_a !== '0) begin
         fails++;
         $display("FAIL reset_mid v=%b rdy=%b got=%h required 0 1 0",
                  a_out_valid, a_in_ready, got_a);
      end
   endtask

   task automatic test_params();
      exp_t e32, e64, e16;
      e32 = model(32'h002081BB, 32'h600, 32, 32);
      e64 = model(32'h002081BB, 32'h600, 64, 32);
      out_ready = 1'b1;
      drive(1'b1, 32'h002081BB, 32'h600);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (a_illegal !== 1'b1 || a_ctrl.reg_write !== 1'b0 || got_a !== e32) begin
         fails++;
         $display("FAIL addw_rv32 il=%b rw=%b got=%h required 1 0 %h",
                  a_illegal, a_ctrl.reg_write, got_a, e32);
      end
      tests++;
      if (b_out_valid !== 1'b1 || b_in_ready !== 1'b1 ||
          b_illegal !== 1'b0 || b_ctrl.reg_write !== 1'b1) begin
         fails++;
         $display("FAIL addw_rv64 v=%b rdy=%b il=%b rw=%b required 1 1 0 1",
                  b_out_valid, b_in_ready, b_illegal, b_ctrl.reg_write);
      end
      tests++;
      if ({b_pc, b_dec, b_imm, b_ctrl, b_branch, b_jump, b_illegal} !==
          {32'h0, e64.pc, e64.dec, {32{e64.imm[31]}}, e64.imm,
           e64.ctrl, e64.br, e64.jp, e64.il}) begin
         fails++;
         $display("FAIL addw_rv64_model imm=%h ctrl=%h required %h %h",
                  b_imm, b_ctrl, e64.imm, e64.ctrl);
      end
      e16 = model(32'h00100893, 32'h604, 32, 16);
      drive(1'b1, 32'h00100893, 32'h604);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tests++;
      if (c_out_valid !== 1'b1 || c_in_ready !== 1'b1 || c_illegal !== 1'b1 ||
          c_ctrl.reg_write !== 1'b0 || got_c !== e16) begin
         fails++;
         $display("FAIL rv32e_x17 v=%b il=%b got=%h required 1 1 %h",
                  c_out_valid, c_illegal, got_c, e16);
      end
      tests++;
      if (a_illegal !== 1'b0 || a_dec.rd !== 5'd17) begin
         fails++;
         $display("FAIL rv32i_x17 il=%b rd=%0d required 0 17",
                  a_illegal, a_dec.rd);
      end
      tick();
   endtask

   task automatic test_random();
      exp_t        q [$];
      logic        v, rdy, fl, acc, pop;
      logic [31:0] ins, pc;
      for (int i = 0; i < 600; i++) begin
         tests++;
         if (a_in_ready !== (q.size() < 2)) begin
            fails++;
            $display("FAIL rand_ready cyc=%0d got=%b depth=%0d",
                     i, a_in_ready, q.size());
         end
         tests++;
         if (a_out_valid !== (q.size() != 0)) begin
            fails++;
            $display("FAIL rand_valid cyc=%0d got=%b depth=%0d",
                     i, a_out_valid, q.size());
         end
         if (q.size() != 0) begin
            tests++;
            if (got_a !== q[0]) begin
               fails++;
               $display("FAIL rand_data cyc=%0d got=%h required=%h",
                        i, got_a, q[0]);
            end
         end
         v   = $urandom_range(0, 3) != 0;
         rdy = $urandom_range(0, 2) != 0;
         fl  = $urandom_range(0, 30) == 0;
         ins = rand_instr();
         pc  = $urandom;
         drive(v, ins, pc);
         out_ready = rdy;
         flush     = fl;
         acc = v && (q.size() < 2);
         pop = rdy && (q.size() != 0);
         @(posedge clk);
         if (fl) begin
            q.delete();
         end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(model(ins, pc, 32, 32));
         end
         @(negedge clk);
      end
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      test_reset();
      test_addi();
      test_decode_basic();
      test_skid();
      test_flush();
      test_reset_mid();
      test_params();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
